// File: rtl/edge_window_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// edge_window_buffer : two-row line buffer producing 3x3 windows per interior
// pixel of a greyscale frame, pacing the upstream read request.
// Revision: 1.0
// ---------------------------------------------------------------------------
module edge_window_buffer #(
  parameter int MAX_WIDTH = 480,
  parameter int PIX_W     = 8
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               i_start,
  input  logic [8:0]         i_img_width,
  input  logic [8:0]         i_img_height,
  input  logic               i_pix_valid,
  input  logic [PIX_W-1:0]   i_pixel,
  output logic               o_re,
  output logic [9*PIX_W-1:0] o_win,
  output logic               o_win_valid,
  input  logic               i_win_ready,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [8:0] c_max_w   = 9'(MAX_WIDTH);
  localparam logic [8:0] c_min_dim = 9'd3;

  state_t           r_state;
  logic [8:0]       r_w_m1;
  logic [8:0]       r_h_m1;
  logic [8:0]       r_col;
  logic [8:0]       r_row;
  logic             r_valid;
  logic             r_err;
  logic [PIX_W-1:0] r_win [9];
  logic [PIX_W-1:0] r_lb0 [MAX_WIDTH];
  logic [PIX_W-1:0] r_lb1 [MAX_WIDTH];

  logic             w_re;
  logic             w_accept;
  logic             w_load;
  logic             w_dims_ok;
  logic [PIX_W-1:0] w_a;
  logic [PIX_W-1:0] w_b;

  assign w_re      = (r_state == S_RUN) && (!r_valid || i_win_ready);
  assign w_accept  = i_pix_valid && w_re;
  // Emission depends only on the counters, so stale window columns never escape.
  assign w_load    = w_accept && (r_row >= 9'd2) && (r_col >= 9'd2);
  assign w_dims_ok = (i_img_width >= c_min_dim) && (i_img_width <= c_max_w) &&
                     (i_img_height >= c_min_dim);
  assign w_a       = r_lb0[r_col];
  assign w_b       = r_lb1[r_col];

  // Line buffers hold rows r-2 and r-1; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lb0[r_col] <= r_lb1[r_col];
      r_lb1[r_col] <= i_pixel;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= S_IDLE;
      r_w_m1  <= '0;
      r_h_m1  <= '0;
      r_col   <= '0;
      r_row   <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      for (int i = 0; i < 9; i++) r_win[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            if (w_dims_ok) begin
              r_state <= S_RUN;
              r_w_m1  <= i_img_width - 9'd1;
              r_h_m1  <= i_img_height - 9'd1;
              r_col   <= '0;
              r_row   <= '0;
              r_err   <= 1'b0;
            end else begin
              r_err   <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (w_accept) begin
            if (r_col == r_w_m1) begin
              r_col <= '0;
              r_row <= r_row + 9'd1;
              if (r_row == r_h_m1) r_state <= S_DRAIN;
            end else begin
              r_col <= r_col + 9'd1;
            end
          end
        end
        S_DRAIN: begin
          if (r_valid && i_win_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_accept) begin
        for (int k = 0; k < 3; k++) begin
          r_win[3*k]   <= r_win[3*k+1];
          r_win[3*k+1] <= r_win[3*k+2];
        end
        r_win[2] <= w_a;
        r_win[5] <= w_b;
        r_win[8] <= i_pixel;
      end

      if (w_load)           r_valid <= 1'b1;
      else if (i_win_ready) r_valid <= 1'b0;

      if (i_pix_valid && !w_re) r_err <= 1'b1;
    end
  end

  // Row-major packing: p00 in the top slice, p22 in the bottom slice.
  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_pack
      assign o_win[(8-gi)*PIX_W +: PIX_W] = r_win[gi];
    end
  endgenerate

  assign o_re        = w_re;
  assign o_win_valid = r_valid;
  assign o_busy      = (r_state == S_RUN);
  assign o_done      = (r_state == S_DRAIN) && r_valid && i_win_ready;
  assign o_err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_edge_window_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_edge_window_buffer : frame-level model plus directed frames for
// edge_window_buffer. Revision: 1.0
// ---------------------------------------------------------------------------
module tb_edge_window_buffer;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        i_start = 1'b0;
  logic [8:0]  i_img_width = '0;
  logic [8:0]  i_img_height = '0;
  logic        i_pix_valid = 1'b0;
  logic [7:0]  i_pixel = '0;
  logic        o_re;
  logic [71:0] o_win;
  logic        o_win_valid;
  logic        i_win_ready = 1'b0;
  logic        o_busy;
  logic        o_done;
  logic        o_err;

  always #5 clk = ~clk;

  edge_window_buffer #(.MAX_WIDTH(480), .PIX_W(8)) dut (
    .clk(clk), .n_rst(n_rst), .i_start(i_start),
    .i_img_width(i_img_width), .i_img_height(i_img_height),
    .i_pix_valid(i_pix_valid), .i_pixel(i_pixel), .o_re(o_re),
    .o_win(o_win), .o_win_valid(o_win_valid), .i_win_ready(i_win_ready),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [71:0] w9(input logic [7:0] a, b, c, d, e, f, g, h, i);
    return {a, b, c, d, e, f, g, h, i};
  endfunction

  // Frame-level model: stores the accepted image and cuts windows out of it.
  int          m_state = 0;  // 0 idle, 1 run, 2 drain
  int          m_w = 0, m_h = 0, m_cnt = 0;
  bit          m_valid = 0, m_err = 0;
  logic [71:0] m_win = '0;
  logic [7:0]  img [0:4095];
  logic [71:0] cap [$];
  int          done_cnt = 0;

  function automatic logic [71:0] win_at(input int r, input int c);
    logic [71:0] w;
    w = '0;
    for (int rr = 0; rr < 3; rr++)
      for (int cc = 0; cc < 3; cc++)
        w[(8-(3*rr+cc))*8 +: 8] = img[(r-2+rr)*m_w + (c-2+cc)];
    return w;
  endfunction

  always @(negedge clk) begin
    bit exp_re, ld;
    int r, c;
    if (!n_rst) begin
      m_state = 0; m_valid = 0; m_err = 0; m_cnt = 0;
      check("rst_re", o_re, 0);
      check("rst_valid", o_win_valid, 0);
      check("rst_win", o_win, 0);
      check("rst_busy", o_busy, 0);
      check("rst_done", o_done, 0);
      check("rst_err", o_err, 0);
    end else begin
      exp_re = (m_state == 1) && (!m_valid || i_win_ready);
      check("re", o_re, exp_re);
      check("win_valid", o_win_valid, m_valid);
      if (m_valid) check("win", o_win, m_win);
      check("busy", o_busy, m_state == 1);
      check("done", o_done, (m_state == 2) && m_valid && i_win_ready);
      check("err", o_err, m_err);
      if (o_win_valid && i_win_ready) cap.push_back(o_win);
      if (o_done) done_cnt++;

      ld = 0;
      if (m_state == 0 && i_start) begin
        if (i_img_width >= 3 && i_img_width <= 480 && i_img_height >= 3) begin
          m_state = 1; m_w = int'(i_img_width); m_h = int'(i_img_height);
          m_cnt = 0; m_err = 0;
        end else begin
          m_err = 1;
        end
      end else if (m_state == 1 && i_pix_valid && exp_re) begin
        r = m_cnt / m_w;
        c = m_cnt % m_w;
        img[m_cnt] = i_pixel;
        if (r >= 2 && c >= 2) begin
          ld = 1;
          m_win = win_at(r, c);
        end
        m_cnt++;
        if (m_cnt == m_w * m_h) m_state = 2;
      end else if (m_state == 2 && m_valid && i_win_ready) begin
        m_state = 0;
      end
      if (ld) m_valid = 1;
      else if (i_win_ready) m_valid = 0;
      if (i_pix_valid && !exp_re) m_err = 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int w, input int h);
    i_img_width  = 9'(w);
    i_img_height = 9'(h);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  function automatic logic [7:0] pix(input int idx, input int w, input int pmode);
    if (pmode == 0) return 8'(idx);
    return 8'(16 * (idx / w) + (idx % w));
  endfunction

  function automatic logic ready_of(input int rmode, input int cyc);
    if (rmode == 0) return 1'b1;
    if (rmode == 1) return (cyc % 2) == 0;
    return 1'($urandom_range(0, 1));
  endfunction

  // rmode: 0 always ready, 1 toggling, 2 random. stop_at >= 0 aborts mid-frame.
  task automatic run_frame(input int w, input int h, input int pmode, input int rmode,
                           input bit inject, input int stop_at);
    int idx, cyc, dc0;
    bit injected;
    idx = 0; cyc = 0; injected = 0;
    cap.delete();
    dc0 = done_cnt;
    start(w, h);
    while (idx < w * h && cyc < 20000) begin
      i_win_ready = ready_of(rmode, cyc);
      i_pix_valid = 1'b0;
      #1;
      if (inject && !injected && o_win_valid) begin
        i_win_ready = 1'b0;
        #1;
        i_pix_valid = 1'b1;
        i_pixel = 8'hEE;
        injected = 1;
      end else if (o_re) begin
        if (stop_at >= 0 && idx == stop_at) break;
        i_pix_valid = 1'b1;
        i_pixel = pix(idx, w, pmode);
        idx++;
      end
      tick();
      cyc++;
    end
    i_pix_valid = 1'b0;
    if (stop_at < 0) begin
      if (idx < w * h) check("stream_timeout", 0, 1);
      cyc = 0;
      while (done_cnt == dc0 && cyc < 1000) begin
        i_win_ready = ready_of(rmode, cyc);
        tick();
        cyc++;
      end
      if (done_cnt == dc0) check("drain_timeout", 0, 1);
      i_win_ready = 1'b0;
      tick();
      tick();
    end
  endtask

  initial begin
    int dc;
    tick();
    tick();
    n_rst = 1'b1;
    tick();

    // 4x3 ramp, always ready
    dc = done_cnt;
    run_frame(4, 3, 0, 0, 0, -1);
    check("f43_count", cap.size(), 2);
    if (cap.size() >= 2) begin
      check("f43_win0", cap[0], w9(0, 1, 2, 4, 5, 6, 8, 9, 10));
      check("f43_win1", cap[1], w9(1, 2, 3, 5, 6, 7, 9, 10, 11));
    end
    check("f43_done", done_cnt - dc, 1);
    check("f43_idle", o_busy, 0);

    // 5x5, pixel = 16*row+col, toggling ready
    run_frame(5, 5, 1, 1, 0, -1);
    check("f55_count", cap.size(), 9);
    if (cap.size() == 9) begin
      check("f55_p00", cap[0][71:64], 8'h00);
      check("f55_p22", cap[0][7:0], 8'h22);
      check("f55_last", cap[8], w9(8'h22, 8'h23, 8'h24, 8'h32, 8'h33, 8'h34, 8'h42, 8'h43, 8'h44));
    end

    // Illegal dimensions
    start(2, 10);
    tick();
    check("bad_w2_err", o_err, 1);
    check("bad_w2_busy", o_busy, 0);
    check("bad_w2_re", o_re, 0);
    start(481, 3);
    tick();
    check("bad_w481_err", o_err, 1);
    check("bad_w481_busy", o_busy, 0);
    run_frame(3, 3, 0, 2, 0, -1);
    check("f33_err_cleared", o_err, 0);
    check("f33_count", cap.size(), 1);

    // Pixel strobe while o_re is low
    run_frame(5, 4, 0, 0, 1, -1);
    check("drop_err", o_err, 1);
    check("drop_count", cap.size(), 6);

    // Full-width frame
    run_frame(480, 3, 0, 0, 0, -1);
    check("f480_count", cap.size(), 478);
    if (cap.size() == 478) begin
      check("f480_p02", cap[477][55:48], 8'hDF);
      check("f480_p12", cap[477][31:24], 8'hBF);
      check("f480_p22", cap[477][7:0], 8'h9F);
    end

    // Reset mid row 3 of a 6x6 frame, then a clean 4x3 frame
    run_frame(6, 6, 1, 0, 0, 20);
    n_rst = 1'b0;
    tick();
    check("abort_valid", o_win_valid, 0);
    check("abort_re", o_re, 0);
    tick();
    n_rst = 1'b1;
    tick();
    dc = done_cnt;
    run_frame(4, 3, 0, 0, 0, -1);
    check("post_rst_count", cap.size(), 2);
    if (cap.size() >= 1) check("post_rst_win0", cap[0], w9(0, 1, 2, 4, 5, 6, 8, 9, 10));
    check("post_rst_done", done_cnt - dc, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
